// File: rtl/inst_fetch.sv
// inst_fetch: single-issue instruction fetch front end.
//   Keeps the next sequential PC and the PC of the request whose data is
//   returning from a registered-read instruction memory (1-cycle latency).
//   A downstream stall replays the in-flight address so the output holds
//   steady. A redirect overrides everything and squashes the wrong-path
//   instruction that is currently on the outputs.
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   imem_addr       issue address to instruction memory
//   imem_inst       memory data for the previous cycle's imem_addr
//   redirect_valid  taken branch/jump this cycle
//   redirect_pc     redirect target; bits [1:0] are ignored
//   stall           downstream cannot take out_* this cycle
//   out_valid       out_pc/out_inst hold a valid instruction
//   out_pc          address of out_inst
//   out_inst        instruction word (pass-through of imem_inst)
//   fetch_count     number of accepted instructions, wraps mod 2^32
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] fetch_count
);

  // Response-side state: address whose data is on imem_inst this cycle.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
  } resp_t;

  resp_t       resp_q, resp_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] issue_pc;
  logic        accept;

  // Issue priority: redirect, then replay on stall, then sequential.
  // Holding reset forces RESET_PC so the memory sees the restart address
  // even if a redirect happens to be asserted while in reset.
  always_comb begin
    issue_pc = fetch_pc_q;
    if (reset)
      issue_pc = RESET_PC;
    else if (redirect_valid)
      issue_pc = {redirect_pc[31:2], 2'b00};
    else if (stall && resp_q.vld)
      issue_pc = resp_q.pc;
  end

  assign imem_addr = issue_pc;

  // Anything on the outputs during a redirect is wrong-path.
  assign out_valid = resp_q.vld && !redirect_valid;
  assign out_pc    = resp_q.pc;
  assign out_inst  = imem_inst;
  assign accept    = out_valid && !stall;

  always_comb begin
    resp_d.vld = 1'b1;
    resp_d.pc  = issue_pc;
    fetch_pc_d = issue_pc + 32'd4;   // wraps naturally at 2^32
    count_d    = accept ? count_q + 32'd1 : count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q     <= '{vld: 1'b0, pc: RESET_PC};
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
    end else begin
      resp_q     <= resp_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
    end
  end

  assign fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a registered-read memory model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory contents: an addi-like word tagged with its own address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0000_0013 | {a[19:0], 12'h000};
  endfunction

  // Registered read; emits garbage while reset is held.
  always @(posedge clk)
    imem_inst <= reset ? 32'hDEAD_BEEF : memf(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next edge, leaving time to drive then sample.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".inst"}, out_inst, memf(pc));
    chk({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.count", fetch_count, 32'd0);
    tick(); tick();
    chk("rst2.valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.pc", out_pc, 32'h0);
    reset = 1'b0; #1;
    chk("rel.addr", imem_addr, 32'h0);

    // Sequential run
    tick(); chk_out("seq0", 32'h0, 0);
    chk("seq0.addr", imem_addr, 32'h4);
    tick(); chk_out("seq1", 32'h4, 1);
    tick(); chk_out("seq2", 32'h8, 2);
    tick(); chk_out("seq3", 32'hC, 3);
    tick(); chk_out("seq4", 32'h10, 4);
    tick(); chk_out("seq5", 32'h14, 5);

    // Redirect to 0x8 while 0x14 is on the outputs
    redirect_valid = 1'b1; redirect_pc = 32'h8; #1;
    chk("redir.valid", {31'd0, out_valid}, 32'd0);
    chk("redir.addr", imem_addr, 32'h8);
    tick(); redirect_valid = 1'b0; #1;
    chk_out("redir.tgt", 32'h8, 5);

    // Stall for three cycles on 0x8
    stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall.addr", imem_addr, 32'h8);
      chk_out("stall", 32'h8, 5);
      tick();
    end
    stall = 1'b0; #1;
    chk_out("unstall", 32'h8, 5);
    chk("unstall.addr", imem_addr, 32'hC);
    tick(); chk_out("after_stall", 32'hC, 6);

    // Redirect and stall together
    redirect_valid = 1'b1; redirect_pc = 32'h20; stall = 1'b1; #1;
    chk("rs.addr", imem_addr, 32'h20);
    chk("rs.valid", {31'd0, out_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk_out("rs.tgt", 32'h20, 6);
    chk("rs.replay", imem_addr, 32'h20);
    tick(); chk_out("rs.hold", 32'h20, 6);
    stall = 1'b0;
    tick(); chk_out("rs.next", 32'h24, 7);

    // Misaligned target and address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap.valid", {31'd0, out_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk_out("wrap.top", 32'hFFFF_FFFC, 7);
    chk("wrap.next_addr", imem_addr, 32'h0);
    tick(); chk_out("wrap.zero", 32'h0, 8);
    tick(); chk_out("run4", 32'h4, 9);
    tick(); chk_out("run8", 32'h8, 10);
    tick(); chk_out("runC", 32'hC, 11);

    // Asynchronous reset mid-stream, during a stall
    stall = 1'b1; #1;
    reset = 1'b1; #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.count", fetch_count, 32'd0);
    chk("arst.addr", imem_addr, 32'h0);
    tick();
    chk("arst2.valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0; stall = 1'b0; #1;
    tick(); chk_out("restart0", 32'h0, 0);
    tick(); chk_out("restart1", 32'h4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
